// File: rtl/push_button_conditioner.sv
// Board push-button conditioner: synchronises, debounces, toggles and counts presses
// for the PCIe PIO input word, plus one-cycle press pulses for local logic.
module push_button_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [N_KEYS-1:0] key_n_in,
    output logic [31:0]       push_button_export,
    output logic [N_KEYS-1:0] press_pulse
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0]         s1_q;
    logic [N_KEYS-1:0]         s2_q;
    logic [N_KEYS-1:0]         stable_n_q, stable_n_d;
    logic [N_KEYS-1:0]         toggle_q, toggle_d;
    logic [N_KEYS-1:0]         pulse_q, pulse_d;
    logic [N_KEYS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [7:0]                count_q, count_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        stable_n_d = stable_n_q;
        cnt_d      = cnt_q;
        pulse_d    = '0;
        toggle_d   = toggle_q;
        count_d    = count_q;
        for (int i = 0; i < N_KEYS; i++) begin
            // One cycle of agreement restarts the count, which is what rejects bounces.
            if (s2_q[i] == stable_n_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_n_d[i] = s2_q[i];
                cnt_d[i]      = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
            pulse_d[i]  = stable_n_q[i] & ~stable_n_d[i];
            toggle_d[i] = toggle_q[i] ^ pulse_d[i];
            count_d     = count_d + 8'(pulse_d[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            s1_q       <= '1;
            s2_q       <= '1;
            stable_n_q <= '1;
            cnt_q      <= '0;
            toggle_q   <= '0;
            pulse_q    <= '0;
            count_q    <= '0;
        end else begin
            s1_q       <= key_n_in;
            s2_q       <= s1_q;
            stable_n_q <= stable_n_d;
            cnt_q      <= cnt_d;
            toggle_q   <= toggle_d;
            pulse_q    <= pulse_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        push_button_export                = '0;
        push_button_export[N_KEYS-1:0]    = ~stable_n_q;
        push_button_export[8 +: N_KEYS]   = toggle_q;
        push_button_export[23:16]         = count_q;
    end

    assign press_pulse = pulse_q;

endmodule

// File: tb/tb_push_button_conditioner.sv
// Directed bench for push_button_conditioner with DEBOUNCE_CYCLES=4, N_KEYS=4.
module tb_push_button_conditioner;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [3:0]  key_n_in;
    logic [31:0] push_button_export;
    logic [3:0]  press_pulse;

    int checks   = 0;
    int failures = 0;
    int pulse_cnt [4];
    int b2b      = 0;
    logic [3:0] prev_pulse = '0;

    typedef struct {
        logic        rst_n;
        logic [3:0]  key_n;
        logic [31:0] exp_export;
        logic [3:0]  exp_pulse;
    } vec_t;

    vec_t vecs [16];

    push_button_conditioner #(
        .N_KEYS         (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_clk           (clk_clk),
        .reset_reset_n     (reset_reset_n),
        .key_n_in          (key_n_in),
        .push_button_export(push_button_export),
        .press_pulse       (press_pulse)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One active edge, then sample 1 ns later and account for pulses.
    task automatic tick();
        @(posedge clk_clk);
        #1;
        for (int i = 0; i < 4; i++) if (press_pulse[i]) pulse_cnt[i]++;
        if ((press_pulse & prev_pulse) != 4'b0) b2b++;
        prev_pulse = press_pulse;
    endtask

    task automatic hold(input logic [3:0] k, input int n);
        key_n_in = k;
        repeat (n) tick();
    endtask

    task automatic clear_pulse_counts();
        for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
    endtask

    initial begin
        reset_reset_n = 1'b0;
        key_n_in      = 4'hF;
        clear_pulse_counts();

        // Reset, then a clean press and release of key 0, one row per edge.
        vecs[0]  = '{1'b0, 4'hF, 32'h0000_0000, 4'b0000};
        vecs[1]  = '{1'b0, 4'hF, 32'h0000_0000, 4'b0000};
        vecs[2]  = '{1'b1, 4'hE, 32'h0000_0000, 4'b0000};
        vecs[3]  = '{1'b1, 4'hE, 32'h0000_0000, 4'b0000};
        vecs[4]  = '{1'b1, 4'hE, 32'h0000_0000, 4'b0000};
        vecs[5]  = '{1'b1, 4'hE, 32'h0000_0000, 4'b0000};
        vecs[6]  = '{1'b1, 4'hE, 32'h0000_0000, 4'b0000};
        vecs[7]  = '{1'b1, 4'hE, 32'h0001_0101, 4'b0001};
        vecs[8]  = '{1'b1, 4'hE, 32'h0001_0101, 4'b0000};
        vecs[9]  = '{1'b1, 4'hF, 32'h0001_0101, 4'b0000};
        vecs[10] = '{1'b1, 4'hF, 32'h0001_0101, 4'b0000};
        vecs[11] = '{1'b1, 4'hF, 32'h0001_0101, 4'b0000};
        vecs[12] = '{1'b1, 4'hF, 32'h0001_0101, 4'b0000};
        vecs[13] = '{1'b1, 4'hF, 32'h0001_0101, 4'b0000};
        vecs[14] = '{1'b1, 4'hF, 32'h0001_0100, 4'b0000};
        vecs[15] = '{1'b1, 4'hF, 32'h0001_0100, 4'b0000};

        for (int v = 0; v < 16; v++) begin
            reset_reset_n = vecs[v].rst_n;
            key_n_in      = vecs[v].key_n;
            tick();
            check($sformatf("vec%0d_export", v), push_button_export, vecs[v].exp_export);
            check($sformatf("vec%0d_pulse", v), {28'b0, press_pulse}, {28'b0, vecs[v].exp_pulse});
        end

        // Bounce on key 1: three-cycle lows never survive the debounce window.
        clear_pulse_counts();
        for (int ph = 0; ph < 4; ph++) begin
            key_n_in = (ph % 2 == 0) ? 4'b1101 : 4'b1111;
            for (int c = 0; c < 3; c++) begin
                tick();
                check($sformatf("bounce_p%0d_c%0d", ph, c), push_button_export, 32'h0001_0100);
            end
        end
        hold(4'b1111, 6);
        check("bounce_export_settled_hi", push_button_export, 32'h0001_0100);
        check("bounce_no_pulse", pulse_cnt[1], 0);
        hold(4'b1101, 6);
        check("bounce_final_press", push_button_export, 32'h0002_0302);
        check("bounce_one_pulse", pulse_cnt[1], 1);
        hold(4'b1111, 7);

        // Preload the count to 254 with 252 more key-0 presses.
        for (int n = 0; n < 252; n++) begin
            hold(4'b1110, 7);
            hold(4'b1111, 7);
        end
        check("preload_254", push_button_export, 32'h00FE_0300);

        // Keys 2 and 3 on the same edge: count wraps 254 + 2 -> 0.
        hold(4'b0011, 5);
        check("simul_pre_pulse", {28'b0, press_pulse}, 32'h0);
        tick();
        check("simul_pulse", {28'b0, press_pulse}, 32'hC);
        check("simul_wrap_export", push_button_export, 32'h0000_0F0C);
        tick();
        check("simul_pulse_drop", {28'b0, press_pulse}, 32'h0);
        hold(4'b1111, 7);
        check("simul_release", push_button_export, 32'h0000_0F00);

        // Reset while key 0's debounce is in progress; key held through reset.
        hold(4'b1110, 4);
        reset_reset_n = 1'b0;
        tick();
        check("midrst_export0", push_button_export, 32'h0);
        check("midrst_pulse0", {28'b0, press_pulse}, 32'h0);
        tick();
        check("midrst_export1", push_button_export, 32'h0);
        reset_reset_n = 1'b1;
        clear_pulse_counts();
        repeat (5) tick();
        check("midrst_no_early_pulse", pulse_cnt[0], 0);
        tick();
        check("midrst_pulse", {28'b0, press_pulse}, 32'h1);
        check("midrst_export", push_button_export, 32'h0001_0101);
        repeat (3) tick();
        check("midrst_single_event", pulse_cnt[0], 1);
        hold(4'b1111, 7);

        // Toggle: three press/release cycles on key 3 from a fresh reset.
        reset_reset_n = 1'b0;
        repeat (2) tick();
        reset_reset_n = 1'b1;
        clear_pulse_counts();
        hold(4'b0111, 7);
        hold(4'b1111, 7);
        check("toggle_after1", push_button_export, 32'h0001_0800);
        hold(4'b0111, 7);
        hold(4'b1111, 7);
        check("toggle_after2", push_button_export, 32'h0002_0000);
        hold(4'b0111, 7);
        hold(4'b1111, 7);
        check("toggle_after3", push_button_export, 32'h0003_0800);
        check("toggle_pulses", pulse_cnt[3], 3);

        check("no_back_to_back", b2b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
